johnson_seq_monitor: RTL and testbench

- Sits directly downstream of johnson_ctr and consumes its `out` bus every sampled cycle.
- Decodes the Johnson code into a phase index and checks every step for legality and correct succession.
- Runs a lock state machine, counts full revolutions, and raises error flags that can be used as a run-time integrity checker for the counter.

---
 rtl/johnson_pkg.sv | 53 +++++
 rtl/johnson_decode.sv | 22 ++
 rtl/johnson_seq_monitor.sv | 146 ++++++++++++++
 tb/tb_johnson_seq_monitor.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared types and helpers for Johnson-code sequence checkers.
// Includes the lock FSM state type, phase-width sizing and the combinational code decoder.
package johnson_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic       legal;
    logic [7:0] phase;
  } decode_t;

  function automatic int phaseWidth(input int width);
    return $clog2(2 * width);
  endfunction

  // A legal code is k ones packed at the MSB end, or k ones packed at the LSB end with MSB clear.
  function automatic decode_t johnsonDecode(input logic [MAX_WIDTH-1:0] code, input int width);
    decode_t              res;
    int                   k;
    logic                 msb;
    logic [MAX_WIDTH-1:0] masked;
    logic [MAX_WIDTH-1:0] msbPat;
    logic [MAX_WIDTH-1:0] lsbPat;
    k      = 0;
    msb    = 1'b0;
    masked = '0;
    msbPat = '0;
    lsbPat = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        masked[i] = code[i];
        if (code[i]) k++;
        if (i == width - 1) msb = code[i];
      end
    end
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        msbPat[i] = (i >= width - k);
        lsbPat[i] = (i < k);
      end
    end
    res.legal = (masked == msbPat) || ((masked == lsbPat) && !msb);
    res.phase = (msb || (k == 0)) ? 8'(k) : 8'(2 * width - k);
    return res;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Purely combinational Johnson-code decoder: flags legality and yields the phase index.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]           code_i,
  output logic                       legal_o,
  output logic [$clog2(2*WIDTH)-1:0] phase_o
);

  localparam int PW = phaseWidth(WIDTH);

  decode_t dec;
  logic    unusedDecodeBits;

  assign dec              = johnsonDecode(MAX_WIDTH'(code_i), WIDTH);
  assign legal_o          = dec.legal;
  assign phase_o          = dec.phase[PW-1:0];
  assign unusedDecodeBits = ^dec.phase;

endmodule

// File: rtl/johnson_seq_monitor.sv
// Run-time integrity checker for a Johnson counter: decodes each sample, tracks lock,
// counts revolutions while locked and reports illegal codes and out-of-order steps.
module johnson_seq_monitor
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           code_in,
  input  logic                       in_valid,
  input  logic                       clr_err,
  output logic [$clog2(2*WIDTH)-1:0] phase,
  output logic                       phase_valid,
  output logic                       locked,
  output logic                       err_illegal,
  output logic                       err_skip,
  output logic                       err_sticky,
  output logic                       rev_pulse,
  output logic [CNT_W-1:0]           rev_count
);

  localparam int            PW         = phaseWidth(WIDTH);
  localparam logic [PW-1:0] LAST_PHASE = PW'(2 * WIDTH - 1);

  lock_state_e        state_q, state_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic               phaseValid_q, phaseValid_d;
  logic [3:0]         stepCnt_q, stepCnt_d;
  logic [CNT_W-1:0]   revCount_q, revCount_d;
  logic               revPulse_q, revPulse_d;
  logic               errIllegal_q, errIllegal_d;
  logic               errSkip_q, errSkip_d;
  logic               errSticky_q, errSticky_d;

  logic               decLegal;
  logic [PW-1:0]      decPhase;
  logic [PW-1:0]      expPhase;
  logic               isNext;

  johnson_decode #(
    .WIDTH (WIDTH)
  ) u_decode (
    .code_i  (code_in),
    .legal_o (decLegal),
    .phase_o (decPhase)
  );

  assign expPhase = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
  assign isNext   = (decPhase == expPhase);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    phaseValid_d = phaseValid_q;
    stepCnt_d    = stepCnt_q;
    revCount_d   = revCount_q;
    revPulse_d   = 1'b0;
    errIllegal_d = 1'b0;
    errSkip_d    = 1'b0;
    if (in_valid) begin
      // Any illegal code abandons tracking; phase keeps its last legal value.
      if (!decLegal) begin
        errIllegal_d = 1'b1;
        phaseValid_d = 1'b0;
        stepCnt_d    = '0;
        state_d      = UNLOCKED;
      end else begin
        phase_d      = decPhase;
        phaseValid_d = 1'b1;
        unique case (state_q)
          UNLOCKED: begin
            stepCnt_d = '0;
            state_d   = ACQUIRE;
          end
          ACQUIRE: begin
            if (isNext) begin
              stepCnt_d = stepCnt_q + 1'b1;
              if (stepCnt_d == 4'(LOCK_CNT)) state_d = LOCKED;
            end else begin
              errSkip_d = 1'b1;
              stepCnt_d = '0;
            end
          end
          LOCKED: begin
            if (isNext) begin
              if (phase_q == LAST_PHASE) begin
                revPulse_d = 1'b1;
                revCount_d = revCount_q + 1'b1;
              end
            end else begin
              errSkip_d = 1'b1;
              stepCnt_d = '0;
              state_d   = ACQUIRE;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end
    // A fresh error outranks a coincident clear request.
    if (errIllegal_d || errSkip_d) begin
      errSticky_d = 1'b1;
    end else if (clr_err) begin
      errSticky_d = 1'b0;
    end else begin
      errSticky_d = errSticky_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= UNLOCKED;
      phase_q      <= '0;
      phaseValid_q <= 1'b0;
      stepCnt_q    <= '0;
      revCount_q   <= '0;
      revPulse_q   <= 1'b0;
      errIllegal_q <= 1'b0;
      errSkip_q    <= 1'b0;
      errSticky_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      phaseValid_q <= phaseValid_d;
      stepCnt_q    <= stepCnt_d;
      revCount_q   <= revCount_d;
      revPulse_q   <= revPulse_d;
      errIllegal_q <= errIllegal_d;
      errSkip_q    <= errSkip_d;
      errSticky_q  <= errSticky_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phaseValid_q;
  assign locked      = (state_q == LOCKED);
  assign err_illegal = errIllegal_q;
  assign err_skip    = errSkip_q;
  assign err_sticky  = errSticky_q;
  assign rev_pulse   = revPulse_q;
  assign rev_count   = revCount_q;

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Directed self-checking bench for johnson_seq_monitor with WIDTH=4, LOCK_CNT=2.
module tb_johnson_seq_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] code_in;
  logic       in_valid;
  logic       clr_err;
  logic [2:0] phase;
  logic       phase_valid;
  logic       locked;
  logic       err_illegal;
  logic       err_skip;
  logic       err_sticky;
  logic       rev_pulse;
  logic [7:0] rev_count;

  int checkCount = 0;
  int failCount  = 0;

  logic [3:0] seqCodes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                               4'b1111, 4'b0111, 4'b0011, 4'b0001};

  johnson_seq_monitor #(
    .WIDTH    (4),
    .LOCK_CNT (2),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .code_in     (code_in),
    .in_valid    (in_valid),
    .clr_err     (clr_err),
    .phase       (phase),
    .phase_valid (phase_valid),
    .locked      (locked),
    .err_illegal (err_illegal),
    .err_skip    (err_skip),
    .err_sticky  (err_sticky),
    .rev_pulse   (rev_pulse),
    .rev_count   (rev_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then look at outputs just after the sampling edge.
  task automatic applyStimulus(input logic [3:0] code, input logic valid,
                               input logic clr, input logic rst);
    @(negedge clk);
    reset    = rst;
    code_in  = code;
    in_valid = valid;
    clr_err  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int ePhase, input int ePv, input int eLocked,
                          input int eIll, input int eSkip, input int eSticky,
                          input int eRev, input int eCnt);
    checkOutput({tag, ".phase"},       int'(phase),       ePhase);
    checkOutput({tag, ".phase_valid"}, int'(phase_valid), ePv);
    checkOutput({tag, ".locked"},      int'(locked),      eLocked);
    checkOutput({tag, ".err_illegal"}, int'(err_illegal), eIll);
    checkOutput({tag, ".err_skip"},    int'(err_skip),    eSkip);
    checkOutput({tag, ".err_sticky"},  int'(err_sticky),  eSticky);
    checkOutput({tag, ".rev_pulse"},   int'(rev_pulse),   eRev);
    checkOutput({tag, ".rev_count"},   int'(rev_count),   eCnt);
  endtask

  initial begin
    reset    = 1'b1;
    code_in  = 4'b0000;
    in_valid = 1'b0;
    clr_err  = 1'b0;

    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // Lock acquisition: locked appears after the third consecutive sample.
    for (int p = 0; p < 4; p++) begin
      applyStimulus(seqCodes[p], 1'b1, 1'b0, 1'b0);
      checkAll($sformatf("lockup%0d", p), p, 1, int'(p >= 2), 0, 0, 0, 0, 0);
    end

    for (int s = 0; s < 5; s++) begin
      applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
      checkAll($sformatf("stall%0d", s), 3, 1, 1, 0, 0, 0, 0, 0);
    end

    for (int p = 4; p < 8; p++) begin
      applyStimulus(seqCodes[p], 1'b1, 1'b0, 1'b0);
      checkAll($sformatf("resume%0d", p), p, 1, 1, 0, 0, 0, 0, 0);
    end

    for (int r = 1; r <= 3; r++) begin
      for (int p = 0; p < 8; p++) begin
        applyStimulus(seqCodes[p], 1'b1, 1'b0, 1'b0);
        checkAll($sformatf("rev%0d_%0d", r, p), p, 1, 1, 0, 0, 0, int'(p == 0), r);
      end
    end
    checkOutput("revCountThree", int'(rev_count), 3);

    applyStimulus(4'b1010, 1'b1, 1'b0, 1'b0);
    checkAll("illegalLocked", 7, 0, 0, 1, 0, 1, 0, 3);

    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    checkAll("relockA0", 0, 1, 0, 0, 0, 1, 0, 3);
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
    checkAll("relockA1", 1, 1, 0, 0, 0, 1, 0, 3);
    applyStimulus(4'b1100, 1'b1, 1'b0, 1'b0);
    checkAll("relockA2", 2, 1, 1, 0, 0, 1, 0, 3);

    applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0);
    checkAll("skipLocked", 4, 1, 0, 0, 1, 1, 0, 3);
    applyStimulus(4'b0111, 1'b1, 1'b0, 1'b0);
    checkAll("relockB0", 5, 1, 0, 0, 0, 1, 0, 3);
    applyStimulus(4'b0011, 1'b1, 1'b0, 1'b0);
    checkAll("relockB1", 6, 1, 1, 0, 0, 1, 0, 3);

    applyStimulus(4'b0011, 1'b1, 1'b1, 1'b0);
    checkAll("repeatSkipClr", 6, 1, 0, 0, 1, 1, 0, 3);

    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    checkAll("relockC0", 7, 1, 0, 0, 0, 1, 0, 3);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    checkAll("wrapInAcquire", 0, 1, 1, 0, 0, 1, 0, 3);

    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    checkAll("clrErrAlone", 0, 1, 1, 0, 0, 0, 0, 3);

    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b1);
    checkAll("resetLocked", 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    checkAll("acqD0", 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0);
    checkAll("acqD1", 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    checkAll("illegalAcquire", 1, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(4'b1010, 1'b1, 1'b0, 1'b0);
    checkAll("illegalUnlocked", 1, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(4'b1010, 1'b0, 1'b0, 1'b0);
    checkAll("pulsesDrop", 1, 0, 0, 0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
